// File: rtl/jtsdram_pkg.sv
// jtsdram_pkg: shared address width, FSM states and the address-derived data pattern
package jtsdram_pkg;
   localparam int SDRAM_AW = 22;

   typedef enum logic [2:0] {IDLE, REFRESH, ACK, WAIT, RDY} state_t;

   // Reference pattern shared with testers that check read data
   function automatic logic [15:0] pat(input logic [SDRAM_AW-1:0] a);
      return a[15:0] ^ {10'd0, a[21:16]};
   endfunction
endpackage

// File: rtl/jtsdram_resp_if.sv
// jtsdram_resp_if: bank-test request/response bus between tester (master) and responder (slave)
interface jtsdram_resp_if;
   import jtsdram_pkg::*;
   logic                rd;
   logic                wr;
   logic [SDRAM_AW-1:0] addr;
   logic                ack;
   logic                rdy;
   logic [31:0]         data_read;
   logic [15:0]         wr_cnt;
   logic                proto_err;
   modport master (output rd, wr, addr, input ack, rdy, data_read, wr_cnt, proto_err);
   modport slave  (input rd, wr, addr, output ack, rdy, data_read, wr_cnt, proto_err);
endinterface

// File: rtl/jtsdram_refresh.sv
// jtsdram_refresh: refresh interval timer, saturates at PERIOD-1 (due) until cleared
module jtsdram_refresh #(
   parameter int PERIOD = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic due
);
   localparam int W = $clog2(PERIOD + 1);
   logic [W-1:0] t;

   assign due = t == W'(PERIOD - 1);

   // Count every cycle, hold at the due value until the FSM services the refresh
   always_ff @(posedge clk) begin
      if (rst || clr) t <= '0;
      else if (!due) t <= t + W'(1);
   end
endmodule

// File: rtl/jtsdram_resp.sv
// jtsdram_resp: SDRAM stand-in answering rd/wr with address-derived data, fixed latencies and refresh stalls
// Define JTSDRAM_ERRINJ_EN to flip data_read[0] on reads of ERR_ADDR.
module jtsdram_resp
   import jtsdram_pkg::*;
#(
   parameter int                  LATENCY        = 4,
   parameter int                  WR_LATENCY     = 2,
   parameter int                  REFRESH_PERIOD = 64,
   parameter int                  REFRESH_LEN    = 6,
   parameter logic [SDRAM_AW-1:0] ERR_ADDR       = 22'h155
) (
   input logic            clk,
   input logic            rst,
   jtsdram_resp_if.slave  bus
);
`ifdef JTSDRAM_ERRINJ_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   state_t              state;
   logic [15:0]         cnt, wait_len;
   logic [SDRAM_AW-1:0] lat_addr;
   logic                is_rd, due, clr, done;
   logic [31:0]         rd_data;

   jtsdram_refresh #(.PERIOD(REFRESH_PERIOD)) u_refresh (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .due (due)
   );

   // Access length, completion condition and the pattern for the latched address
   always_comb begin
      wait_len = is_rd ? 16'(LATENCY - 1) : 16'(WR_LATENCY - 1);
      clr      = state == IDLE && due;
      done     = (state == ACK && wait_len == 16'd0) || (state == WAIT && cnt <= 16'd1);
      rd_data  = {pat(lat_addr + 22'd1), pat(lat_addr)} ^ {31'd0, ERR_EN && lat_addr == ERR_ADDR};
   end

   // Request FSM; ack/rdy are registered so they coincide with the ACK/RDY states
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         lat_addr      <= '0;
         is_rd         <= 1'b0;
         bus.ack       <= 1'b0;
         bus.rdy       <= 1'b0;
         bus.data_read <= '0;
         bus.wr_cnt    <= '0;
         bus.proto_err <= 1'b0;
      end else begin
         bus.ack <= 1'b0;
         bus.rdy <= 1'b0;
         case (state)
            IDLE: begin
               if (due) begin
                  state <= REFRESH;
                  cnt   <= 16'(REFRESH_LEN - 1);
               end else if (bus.rd || bus.wr) begin
                  state    <= ACK;
                  bus.ack  <= 1'b1;
                  lat_addr <= bus.addr;
                  is_rd    <= bus.rd;
                  if (bus.rd && bus.wr) bus.proto_err <= 1'b1;
               end
            end
            REFRESH: begin
               if (cnt == 16'd0) state <= IDLE;
               else cnt <= cnt - 16'd1;
            end
            ACK: begin
               state <= WAIT;
               cnt   <= wait_len;
            end
            WAIT:    cnt <= cnt - 16'd1;
            default: state <= IDLE;
         endcase
         if (done) begin
            state   <= RDY;
            bus.rdy <= 1'b1;
            if (is_rd) bus.data_read <= rd_data;
            else bus.wr_cnt <= bus.wr_cnt + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_jtsdram_resp.sv
// tb_jtsdram_resp: directed requests with a scoreboard checked on every rdy pulse
module tb_jtsdram_resp;
   localparam int LAT  = 4;
   localparam int WLAT = 2;
`ifdef JTSDRAM_ERRINJ_EN
   localparam logic [31:0] ERR_DATA = 32'h0156_0154;
`else
   localparam logic [31:0] ERR_DATA = 32'h0156_0155;
`endif

   typedef struct {
      logic [31:0] data;
      logic [15:0] wcnt;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          cyc = 0;
   int          n = 0;
   int          nerr = 0;
   int          rcyc = 0;
   int          rdy_seen = 0;
   logic [15:0] exp_wr = '0;
   logic [31:0] last = '0;
   exp_t        q[$];
   exp_t        m;

   jtsdram_resp_if bus();

   jtsdram_resp dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every rdy pulse pops one expected response
   always @(negedge clk) begin
      if (!rst && bus.rdy) begin
         if (q.size() == 0) chk("spurious_rdy", 32'd1, 32'd0);
         else begin
            m = q.pop_front();
            chk("rdy_data", bus.data_read, m.data);
            chk("rdy_wr_cnt", {16'd0, bus.wr_cnt}, {16'd0, m.wcnt});
            chk("rdy_cycle", 32'(cyc), 32'(m.cyc));
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      rcyc = cyc;
      q.delete();
      exp_wr = '0;
      last = '0;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_ack"}, {31'd0, bus.ack}, 32'd0);
      chk({nm, "_rdy"}, {31'd0, bus.rdy}, 32'd0);
      chk({nm, "_data"}, bus.data_read, 32'd0);
      chk({nm, "_wr_cnt"}, {16'd0, bus.wr_cnt}, 32'd0);
      chk({nm, "_proto_err"}, {31'd0, bus.proto_err}, 32'd0);
   endtask

   // Issue one request (called just after a posedge), check ack timing, queue the response
   task automatic req(input logic r, input logic w, input logic [21:0] a, input logic [31:0] d, input int dly);
      int   t0, k;
      exp_t e;
      bus.rd = r;
      bus.wr = w;
      bus.addr = a;
      t0 = cyc;
      k = 0;
      @(negedge clk);
      while (!bus.ack && k < 40) begin
         @(negedge clk);
         k++;
      end
      if (!bus.ack) chk("ack_timeout", 32'd0, 32'd1);
      else begin
         chk("ack_cycle", 32'(cyc), 32'(t0 + dly));
         if (r) begin
            last = d;
            e.cyc = cyc + LAT;
         end else begin
            exp_wr++;
            e.cyc = cyc + WLAT;
         end
         e.data = last;
         e.wcnt = exp_wr;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.rd = 1'b0;
      bus.wr = 1'b0;
      k = 0;
      while (q.size() != 0 && k < 40) begin
         @(negedge clk);
         k++;
      end
      if (q.size() != 0) begin
         chk("rdy_timeout", 32'(q.size()), 32'd0);
         q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.rd = 1'b0;
      bus.wr = 1'b0;
      bus.addr = '0;
      do_reset();
      chk_zero("reset");
      req(1'b1, 1'b0, 22'h000003, 32'h0004_0003, 1);
      req(1'b1, 1'b0, 22'h3FFFFF, 32'h0000_FFC0, 1);
      req(1'b1, 1'b0, 22'h010000, 32'h0000_0001, 1);
      req(1'b0, 1'b1, 22'h000010, 32'h0, 1);
      req(1'b1, 1'b0, 22'h000155, ERR_DATA, 1);
      req(1'b0, 1'b1, 22'h000155, 32'h0, 1);
      chk("proto_err_clean", {31'd0, bus.proto_err}, 32'd0);
      do_reset();
      req(1'b0, 1'b1, 22'h000010, 32'h0, 1);
      do_reset();
      repeat (63) @(posedge clk);
      #1;
      req(1'b1, 1'b0, 22'h000020, 32'h0021_0020, 8);
      req(1'b1, 1'b0, 22'h000100, 32'h0101_0100, 1);
      do_reset();
      req(1'b1, 1'b1, 22'h000040, 32'h0041_0040, 1);
      chk("proto_err_set", {31'd0, bus.proto_err}, 32'd1);
      req(1'b0, 1'b1, 22'h000040, 32'h0, 1);
      chk("proto_err_sticky", {31'd0, bus.proto_err}, 32'd1);
      bus.rd = 1'b1;
      bus.addr = 22'h000008;
      begin
         int k = 0;
         @(negedge clk);
         while (!bus.ack && k < 40) begin
            @(negedge clk);
            k++;
         end
         chk("mid_ack", {31'd0, bus.ack}, 32'd1);
      end
      @(posedge clk);
      #1;
      bus.rd = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      chk_zero("mid_reset");
      rdy_seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.rdy) rdy_seen++;
      end
      chk("no_rdy_after_reset", 32'(rdy_seen), 32'd0);
      @(posedge clk);
      #1;
      exp_wr = '0;
      last = '0;
      req(1'b1, 1'b0, 22'h000007, 32'h0008_0007, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n, nerr);
      $finish;
   end
endmodule
